// File: rtl/cpu_ram_sync_if.sv
// cpu_ram_sync_if
//   Request/response bus between the CPU control unit and cpu_ram_sync.
//   Parameters DATA_W / ADDR_W must match the RAM instance they connect to.
//
//   Signals:
//     req, we, addr, wdata      master -> slave   access request (qualified by ready)
//     ready                     slave  -> master  slave accepts a request this cycle
//     rvalid, rdata             slave  -> master  registered read response
//     init_done                 slave  -> master  zero-fill after reset finished
//     err                       slave  -> master  out-of-range access was accepted
//     par_err                   slave  -> master  stored parity mismatch on read
//
//   Modports: master (CPU side), slave (RAM side).
interface cpu_ram_sync_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              init_done;
  logic              err;
  logic              par_err;

  modport master (
    output req, we, addr, wdata,
    input  ready, rvalid, rdata, init_done, err, par_err
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, rvalid, rdata, init_done, err, par_err
  );
endinterface

// File: rtl/cpu_ram_sync.sv
// cpu_ram_sync
//   Parametrised single-port synchronous RAM with a registered read port,
//   a req/ready handshake, an optional hardware zero-fill sweep after reset
//   and out-of-range address detection.
//
//   Parameters:
//     DATA_W       data word width
//     ADDR_W       address width
//     DEPTH        implemented words; addresses >= DEPTH are out of range
//     INIT_ON_RST  1 = zero-fill every word after reset (ready low meanwhile)
//
//   Ports:
//     clk          system clock, rising edge
//     rst          synchronous active-high reset
//     bus          cpu_ram_sync_if.slave (req/we/addr/wdata in;
//                  ready/rvalid/rdata/init_done/err/par_err out)
//
//   Optional feature macro: CPU_RAM_PARITY_EN
//     Defined: each word carries an extra even-parity bit written from wdata
//     (INIT writes parity 0); a mismatch on an in-range read pulses par_err
//     together with rvalid. Undefined: no parity storage, par_err is 0.
module cpu_ram_sync #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int DEPTH       = 16,
  parameter int INIT_ON_RST = 1
) (
  input logic           clk,
  input logic           rst,
  cpu_ram_sync_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef CPU_RAM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_t;

  localparam state_t RST_STATE = (INIT_ON_RST != 0) ? ST_INIT : ST_IDLE;
  localparam logic   RST_READY = (INIT_ON_RST != 0) ? 1'b0 : 1'b1;

  logic [WORD_W-1:0] mem_q [DEPTH];

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              init_done_q, init_done_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              par_err_q, par_err_d;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [WORD_W-1:0] mem_wword;
  logic [WORD_W-1:0] rd_word;
  logic [IDX_W-1:0]  addr_idx;
  logic              in_range;
  logic              accept;

  // Range check done at 32 bits so it stays meaningful even when DEPTH
  // fills the whole address space.
  assign in_range = (32'(bus.addr) < 32'(DEPTH));
  assign addr_idx = IDX_W'(bus.addr);
  assign rd_word  = in_range ? mem_q[addr_idx] : '0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    init_done_d = init_done_q;
    rvalid_d    = 1'b0;
    rdata_d     = rdata_q;
    err_d       = 1'b0;
    par_err_d   = 1'b0;
    mem_we      = 1'b0;
    mem_idx     = addr_idx;
    mem_wword   = '0;
    accept      = 1'b0;

    case (state_q)
      ST_INIT: begin
        // Sweep writes an all-zero word (data and parity) each cycle.
        mem_we  = 1'b1;
        mem_idx = cnt_q;
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          ready_d     = 1'b1;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_IDLE: begin
        ready_d     = 1'b1;
        init_done_d = 1'b1;
        accept      = bus.req & ready_q;
        if (accept) begin
          err_d = ~in_range;
          if (bus.we) begin
            mem_we = in_range;
`ifdef CPU_RAM_PARITY_EN
            mem_wword = {^bus.wdata, bus.wdata};
`else
            mem_wword = bus.wdata;
`endif
          end else begin
            // Out-of-range reads return zero but still complete.
            rvalid_d = 1'b1;
            rdata_d  = rd_word[DATA_W-1:0];
`ifdef CPU_RAM_PARITY_EN
            par_err_d = in_range & (rd_word[DATA_W] != ^rd_word[DATA_W-1:0]);
`endif
          end
        end
      end

      default: state_d = RST_STATE;
    endcase
  end

  // Storage has no reset of its own; clearing is done by the INIT sweep.
  // Writes are blocked on a reset edge so reset never disturbs contents.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[mem_idx] <= mem_wword;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RST_STATE;
      cnt_q       <= '0;
      ready_q     <= RST_READY;
      init_done_q <= RST_READY;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      par_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      init_done_q <= init_done_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      par_err_q   <= par_err_d;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.init_done = init_done_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = rdata_q;
  assign bus.err       = err_q;
  assign bus.par_err   = par_err_q;

endmodule

// File: tb/tb_cpu_ram_sync.sv
// tb_cpu_ram_sync
//   Self-checking bench for cpu_ram_sync. Two instances share clk/rst:
//   dut16 (DEPTH=16, full address space) and dut12 (DEPTH=12, addresses
//   12..15 out of range). A behavioural model tracks memory contents and
//   the expected outputs of both; a compare process checks every cycle,
//   and directed sequences add hand-computed literal checks.
//   Optional macro CPU_RAM_PARITY_EN enables the parity sequence.
module tb_cpu_ram_sync;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cpu_ram_sync_if #(.DATA_W(8), .ADDR_W(4)) bus16 ();
  cpu_ram_sync_if #(.DATA_W(8), .ADDR_W(4)) bus12 ();

  cpu_ram_sync #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .INIT_ON_RST(1)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  cpu_ram_sync #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .INIT_ON_RST(1)) dut12 (
    .clk (clk),
    .rst (rst),
    .bus (bus12)
  );

  int total = 0;
  int bad   = 0;

  // Model state, index 0 = dut16, index 1 = dut12
  int         depth_of [2] = '{16, 12};
  logic [7:0] m_mem    [2][16];
  logic       m_par    [2][16];
  int         m_busy   [2];
  logic       e_ready  [2];
  logic       e_init   [2];
  logic       e_rvalid [2];
  logic       e_err    [2];
  logic       e_par    [2];
  logic [7:0] e_rdata  [2];
  bit         live = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs on the selected instance; the other idles.
  task automatic applyStimulus(input int inst, input logic r, input logic w,
                               input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    if (inst == 0) begin
      bus16.req = r; bus16.we = w; bus16.addr = a; bus16.wdata = d;
      bus12.req = 1'b0;
    end else begin
      bus12.req = r; bus12.we = w; bus12.addr = a; bus12.wdata = d;
      bus16.req = 1'b0;
    end
  endtask

  // Behavioural model: INIT is a countdown of DEPTH zero-writes, then each
  // accepted request is applied to an array and its response predicted.
  always @(posedge clk) begin
    logic       r, w, inr;
    logic [3:0] a;
    logic [7:0] d;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        r = bus16.req; w = bus16.we; a = bus16.addr; d = bus16.wdata;
      end else begin
        r = bus12.req; w = bus12.we; a = bus12.addr; d = bus12.wdata;
      end
      e_rvalid[k] = 1'b0;
      e_err[k]    = 1'b0;
      e_par[k]    = 1'b0;
      if (rst) begin
        live        = 1'b1;
        m_busy[k]   = depth_of[k];
        e_ready[k]  = 1'b0;
        e_init[k]   = 1'b0;
        e_rdata[k]  = 8'h00;
      end else if (m_busy[k] > 0) begin
        m_mem[k][depth_of[k] - m_busy[k]] = 8'h00;
        m_par[k][depth_of[k] - m_busy[k]] = 1'b0;
        m_busy[k]--;
        e_ready[k] = (m_busy[k] == 0);
        e_init[k]  = (m_busy[k] == 0);
      end else begin
        e_ready[k] = 1'b1;
        e_init[k]  = 1'b1;
        if (r) begin
          inr      = (int'(a) < depth_of[k]);
          e_err[k] = !inr;
          if (w) begin
            if (inr) begin
              m_mem[k][a] = d;
              m_par[k][a] = ^d;
            end
          end else begin
            e_rvalid[k] = 1'b1;
            e_rdata[k]  = inr ? m_mem[k][a] : 8'h00;
            e_par[k]    = inr && (m_par[k][a] != ^m_mem[k][a]);
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    if (live) begin
      checkOutput("ready16",   bus16.ready,     e_ready[0]);
      checkOutput("init16",    bus16.init_done, e_init[0]);
      checkOutput("rvalid16",  bus16.rvalid,    e_rvalid[0]);
      checkOutput("rdata16",   bus16.rdata,     e_rdata[0]);
      checkOutput("err16",     bus16.err,       e_err[0]);
      checkOutput("par_err16", bus16.par_err,   e_par[0]);
      checkOutput("ready12",   bus12.ready,     e_ready[1]);
      checkOutput("init12",    bus12.init_done, e_init[1]);
      checkOutput("rvalid12",  bus12.rvalid,    e_rvalid[1]);
      checkOutput("rdata12",   bus12.rdata,     e_rdata[1]);
      checkOutput("err12",     bus12.err,       e_err[1]);
      checkOutput("par_err12", bus12.par_err,   e_par[1]);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] lit_data [4];
    int n;
    int seen;
    lit_data = '{8'hA5, 8'h3C, 8'hFF, 8'h01};

    rst = 1'b1;
    bus16.req = 1'b0; bus16.we = 1'b0; bus16.addr = '0; bus16.wdata = '0;
    bus12.req = 1'b0; bus12.we = 1'b0; bus12.addr = '0; bus12.wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready",  bus16.ready,     1'b0);
    checkOutput("rst_init",   bus16.init_done, 1'b0);
    checkOutput("rst_rvalid", bus16.rvalid,    1'b0);
    checkOutput("rst_rdata",  bus16.rdata,     8'h00);
    checkOutput("rst_err",    bus16.err,       1'b0);
    rst = 1'b0;

    // Zero-fill lasts exactly DEPTH cycles after release
    n = 0;
    while (bus16.init_done !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("init_cycles16", n, 16);
    checkOutput("ready_after_init", bus16.ready, 1'b1);

    applyStimulus(0, 1'b1, 1'b0, 4'hc, 8'h00);
    @(posedge clk); #1;
    checkOutput("rd_c_zero_rvalid", bus16.rvalid, 1'b1);
    checkOutput("rd_c_zero_data",   bus16.rdata,  8'h00);

    // Four writes then four back-to-back reads
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1'b1, 1'b1, 4'(12 + i), lit_data[i]);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1'b1, 1'b0, 4'(12 + i), 8'h00);
      @(posedge clk); #1;
      checkOutput("burst_rvalid", bus16.rvalid, 1'b1);
      checkOutput("burst_rdata",  bus16.rdata,  lit_data[i]);
    end
    applyStimulus(0, 1'b0, 1'b0, 4'h0, 8'h00);
    @(posedge clk); #1;
    checkOutput("rvalid_drops", bus16.rvalid, 1'b0);
    checkOutput("rdata_holds",  bus16.rdata,  8'h01);

    // Write then immediate read of the same address
    applyStimulus(0, 1'b1, 1'b1, 4'h3, 8'h5A);
    applyStimulus(0, 1'b1, 1'b0, 4'h3, 8'h00);
    @(posedge clk); #1;
    checkOutput("wr_rd_3", bus16.rdata, 8'h5A);

    // DEPTH=12: boundary and out-of-range accesses
    applyStimulus(1, 1'b1, 1'b1, 4'h1, 8'h11);
    applyStimulus(1, 1'b1, 1'b1, 4'hb, 8'h66);
    applyStimulus(1, 1'b1, 1'b0, 4'hb, 8'h00);
    @(posedge clk); #1;
    checkOutput("d12_rd_b",     bus12.rdata, 8'h66);
    checkOutput("d12_rd_b_err", bus12.err,   1'b0);
    applyStimulus(1, 1'b1, 1'b1, 4'hd, 8'h77);
    @(posedge clk); #1;
    checkOutput("d12_wr_d_err",    bus12.err,    1'b1);
    checkOutput("d12_wr_d_rvalid", bus12.rvalid, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 4'hd, 8'h00);
    @(posedge clk); #1;
    checkOutput("d12_rd_d_data",   bus12.rdata,  8'h00);
    checkOutput("d12_rd_d_rvalid", bus12.rvalid, 1'b1);
    checkOutput("d12_rd_d_err",    bus12.err,    1'b1);
    applyStimulus(1, 1'b1, 1'b0, 4'h1, 8'h00);
    @(posedge clk); #1;
    checkOutput("d12_rd_1", bus12.rdata, 8'h11);
    checkOutput("d12_err_clear", bus12.err, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 4'hc, 8'h00);
    @(posedge clk); #1;
    checkOutput("d12_rd_c_err", bus12.err, 1'b1);

    // Fill and read back every address on both instances
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) applyStimulus(k, 1'b1, 1'b1, 4'(i), 8'(i * 37 + 5));
      for (int i = 0; i < 16; i++) applyStimulus(k, 1'b1, 1'b0, 4'(i), 8'h00);
    end
    applyStimulus(0, 1'b0, 1'b0, 4'h0, 8'h00);

    // Requests during INIT are ignored; reset mid-INIT restarts the sweep
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 1'b1, 1'b0, 4'h5, 8'h00);
      @(posedge clk); #1;
      if (bus16.rvalid !== 1'b0 || bus16.err !== 1'b0) seen++;
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n = 0;
    while (bus16.init_done !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
      if (bus16.init_done !== 1'b1 && (bus16.rvalid !== 1'b0 || bus16.err !== 1'b0)) seen++;
    end
    checkOutput("init_restart_cycles", n, 16);
    checkOutput("init_req_ignored", seen, 0);
    applyStimulus(0, 1'b1, 1'b0, 4'h5, 8'h00);
    @(posedge clk); #1;
    checkOutput("rd_after_reinit", bus16.rdata, 8'h00);
    applyStimulus(0, 1'b0, 1'b0, 4'h0, 8'h00);

`ifdef CPU_RAM_PARITY_EN
    applyStimulus(0, 1'b1, 1'b1, 4'h2, 8'h81);
    applyStimulus(0, 1'b0, 1'b0, 4'h0, 8'h00);
    dut16.mem_q[2][0] = ~dut16.mem_q[2][0];
    m_mem[0][2][0]    = ~m_mem[0][2][0];
    applyStimulus(0, 1'b1, 1'b0, 4'h2, 8'h00);
    @(posedge clk); #1;
    checkOutput("par_flip_data",   bus16.rdata,   8'h80);
    checkOutput("par_flip_rvalid", bus16.rvalid,  1'b1);
    checkOutput("par_flip_err",    bus16.par_err, 1'b1);
    applyStimulus(0, 1'b0, 1'b0, 4'h0, 8'h00);
    dut16.mem_q[2][0] = ~dut16.mem_q[2][0];
    m_mem[0][2][0]    = ~m_mem[0][2][0];
    applyStimulus(0, 1'b1, 1'b0, 4'h2, 8'h00);
    @(posedge clk); #1;
    checkOutput("par_clean_data", bus16.rdata,   8'h81);
    checkOutput("par_clean_err",  bus16.par_err, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 4'h0, 8'h00);
`endif

    repeat (2) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
